// File: rtl/matriz_pkg.sv
// rtl/matriz_pkg.sv - shared matrix datapath constants, state enum and N2 helper
//
// Shared by subtracao and soma.
//   TAMANHO_PADRAO : default matrix dimension
//   LARGURA_PADRAO : default element width in bits
//   estado_t       : load/drain state of the streaming matrix blocks
//   n2()           : number of elements in a TAMANHO x TAMANHO matrix

package matriz_pkg;

    localparam int TAMANHO_PADRAO = 5;
    localparam int LARGURA_PADRAO = 8;

    typedef enum logic {
        CARGA = 1'b0,
        SAIDA = 1'b1
    } estado_t;

    function automatic int n2(input int tamanho);
        return tamanho * tamanho;
    endfunction

endpackage

// File: rtl/subtracao_if.sv
// rtl/subtracao_if.sv - input pair stream and output element stream of subtracao
//
// Signals:
//   in_valid/in_ready/in_a/in_b           : pair stream (A element, B element)
//   out_valid/out_ready/out_c/out_neg/out_last : difference stream, row-major
// Modports:
//   slave  : the subtractor's view
//   master : the producer/consumer view

interface subtracao_if #(
    parameter int LARGURA = matriz_pkg::LARGURA_PADRAO
);

    logic               in_valid;
    logic               in_ready;
    logic [LARGURA-1:0] in_a;
    logic [LARGURA-1:0] in_b;

    logic               out_valid;
    logic               out_ready;
    logic [LARGURA-1:0] out_c;
    logic               out_neg;
    logic               out_last;

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_c, out_neg, out_last
    );

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_c, out_neg, out_last
    );

endinterface

// File: rtl/subtracao_elem.sv
// rtl/subtracao_elem.sv - combinational element subtractor with borrow flag
//
// Ports:
//   a, b : unsigned operands
//   diff : a - b, wrapping by default, clamped to 0 when a < b if
//          SUBTRACAO_SAT_EN is defined
//   neg  : 1 when a < b, in either build
// Build macro: SUBTRACAO_SAT_EN

module subtracao_elem #(
    parameter int LARGURA = 8
) (
    input  logic [LARGURA-1:0] a,
    input  logic [LARGURA-1:0] b,
    output logic [LARGURA-1:0] diff,
    output logic               neg
);

    logic [LARGURA-1:0] bruto;

    always_comb begin
        bruto = a - b;
        neg   = (a < b);
`ifdef SUBTRACAO_SAT_EN
        diff  = neg ? '0 : bruto;
`else
        diff  = bruto;
`endif
    end

endmodule

// File: rtl/subtracao.sv
// rtl/subtracao.sv - streaming element-wise matrix subtractor C = A - B
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : subtracao_if.slave; loads N2 pairs row-major, then drains N2
//           differences row-major with borrow flag and last marker
// Build macro: SUBTRACAO_SAT_EN (saturating subtraction, see subtracao_elem)

module subtracao
    import matriz_pkg::*;
#(
    parameter int TAMANHO = TAMANHO_PADRAO,
    parameter int LARGURA = LARGURA_PADRAO
) (
    input  logic        clk,
    input  logic        rst_n,
    subtracao_if.slave  bus
);

    localparam int N2 = n2(TAMANHO);
    localparam int IW = (N2 > 1) ? $clog2(N2) : 1;
    localparam logic [IW-1:0] IDX_ULT = IW'(N2 - 1);

    estado_t          state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    // Each slot holds {borrow, difference}.
    logic [LARGURA:0] mem_q [N2];

    logic [LARGURA-1:0] elem_diff;
    logic               elem_neg;
    logic               accept;
    logic               handshake;
    logic [LARGURA:0]   slot_rd;

    subtracao_elem #(
        .LARGURA (LARGURA)
    ) u_elem (
        .a    (bus.in_a),
        .b    (bus.in_b),
        .diff (elem_diff),
        .neg  (elem_neg)
    );

    // Ready/valid are flops, so neither depends combinationally on the
    // opposite handshake input.
    assign accept    = bus.in_valid && in_ready_q;
    assign handshake = out_valid_q && bus.out_ready;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            CARGA: begin
                if (accept) begin
                    if (idx_q == IDX_ULT) begin
                        state_d     = SAIDA;
                        idx_d       = '0;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            SAIDA: begin
                if (handshake) begin
                    if (idx_q == IDX_ULT) begin
                        state_d     = CARGA;
                        idx_d       = '0;
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d     = CARGA;
                idx_d       = '0;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= CARGA;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Buffer is not reset: a fresh load overwrites every slot before it is read.
    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            mem_q[idx_q] <= {elem_neg, elem_diff};
        end
    end

    assign slot_rd = mem_q[idx_q];

    // Data outputs are gated to zero while no element is being offered.
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_c     = out_valid_q ? slot_rd[LARGURA-1:0] : '0;
    assign bus.out_neg   = out_valid_q && slot_rd[LARGURA];
    assign bus.out_last  = out_valid_q && (idx_q == IDX_ULT);

endmodule

// File: tb/tb_subtracao.sv
// tb/tb_subtracao.sv - directed self-checking bench for subtracao

module tb_subtracao;
    import matriz_pkg::*;

    localparam int N2 = n2(TAMANHO_PADRAO);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    subtracao_if #(.LARGURA(8)) bus ();

    subtracao #(.TAMANHO(TAMANHO_PADRAO), .LARGURA(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    logic [7:0] src_a[$], src_b[$];
    logic [7:0] exp_c[$];
    logic       exp_neg[$];
    logic [7:0] got_c[$];
    logic       got_neg[$], got_last[$];
    int         acc_cyc[$], hs_cyc[$];
    int         valid_first;
    int         stall_viol, ready_viol;
    bit         gap_mode, stall_mode, hold_valid;

    // Drives inputs and samples outputs on the falling edge; a handshake is
    // logged when both sides are asserted going into the next rising edge.
    task automatic run(input int n_out);
        int fed = 0;
        int budget = 0;
        bit pend = 0;
        bit tog = 0;
        logic [7:0] hc;
        logic hn, hl;
        got_c.delete(); got_neg.delete(); got_last.delete();
        acc_cyc.delete(); hs_cyc.delete();
        valid_first = -1; stall_viol = 0; ready_viol = 0;
        while (got_c.size() < n_out) begin
            @(negedge clk);
            budget++;
            if (budget > 2000) begin
                chk("timeout", 1, 0);
                break;
            end
            if (pend) begin
                if (!bus.out_valid || bus.out_c !== hc || bus.out_neg !== hn || bus.out_last !== hl)
                    stall_viol++;
                pend = 0;
            end
            if (bus.out_valid && bus.in_ready) ready_viol++;
            if (bus.out_valid && valid_first < 0) valid_first = cyc;
            tog = !tog;
            bus.out_ready = stall_mode ? tog : 1'b1;
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    got_c.push_back(bus.out_c);
                    got_neg.push_back(bus.out_neg);
                    got_last.push_back(bus.out_last);
                    hs_cyc.push_back(cyc);
                end else begin
                    pend = 1; hc = bus.out_c; hn = bus.out_neg; hl = bus.out_last;
                end
            end
            if (fed < src_a.size()) begin
                bus.in_valid = gap_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
                bus.in_a = src_a[fed];
                bus.in_b = src_b[fed];
                if (bus.in_valid && bus.in_ready) begin
                    acc_cyc.push_back(cyc);
                    fed++;
                end
            end else begin
                bus.in_valid = hold_valid;
                bus.in_a = 8'hAA;
                bus.in_b = 8'h55;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        chk("pairs_fed", fed, src_a.size());
    endtask

    task automatic verify(input string t);
        chk({t, "_count"}, got_c.size(), exp_c.size());
        for (int k = 0; k < exp_c.size() && k < got_c.size(); k++) begin
            chk($sformatf("%s_c%0d", t, k), got_c[k], exp_c[k]);
            chk($sformatf("%s_neg%0d", t, k), got_neg[k], exp_neg[k]);
            chk($sformatf("%s_last%0d", t, k), got_last[k], (k % N2) == N2 - 1);
        end
    endtask

    task automatic clear_vec();
        src_a.delete(); src_b.delete(); exp_c.delete(); exp_neg.delete();
        gap_mode = 0; stall_mode = 0; hold_valid = 0;
    endtask

    task automatic add(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic n);
        src_a.push_back(a); src_b.push_back(b);
        exp_c.push_back(c); exp_neg.push_back(n);
    endtask

    localparam logic [7:0] NEG_ONE =
`ifdef SUBTRACAO_SAT_EN
        8'h00;
`else
        8'hFF;
`endif

    initial begin
        bus.in_valid = 1'b1; bus.in_a = 8'h77; bus.in_b = 8'h00; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_c", bus.out_c, 0);
        chk("rst_out_neg", bus.out_neg, 0);
        chk("rst_out_last", bus.out_last, 0);

        // equal operands, full rate
        clear_vec();
        for (int k = 0; k < N2; k++) add(8'h04, 8'h04, 8'h00, 1'b0);
        run(N2);
        verify("eq");
        chk("eq_latency", valid_first - acc_cyc[N2-1], 1);

        // a = idx, b = 1: only element 0 borrows
        clear_vec();
        add(8'h00, 8'h01, NEG_ONE, 1'b1);
        for (int k = 1; k < N2; k++) add(8'(k), 8'h01, 8'(k - 1), 1'b0);
        run(N2);
        verify("idx");

        // backpressure every other cycle; a = 10k, b = 100
        clear_vec();
        stall_mode = 1;
        for (int k = 0; k < 10; k++) begin
`ifdef SUBTRACAO_SAT_EN
            add(8'(k * 10), 8'd100, 8'h00, 1'b1);
`else
            add(8'(k * 10), 8'd100, 8'(k * 10 + 156), 1'b1);
`endif
        end
        for (int k = 10; k < N2; k++) add(8'(k * 10), 8'd100, 8'(k * 10 - 100), 1'b0);
        run(N2);
        verify("stall");
        chk("stall_stable", stall_viol, 0);

        // random input gaps, in_valid held high through the drain
        clear_vec();
        gap_mode = 1; hold_valid = 1;
        for (int k = 0; k < N2; k++) add(8'hFF, 8'(k), 8'(255 - k), 1'b0);
        run(N2);
        verify("gap");
        chk("gap_ready_in_drain", ready_viol, 0);
        chk("gap_back_ready", bus.in_ready, 1);
        chk("gap_back_valid", bus.out_valid, 0);

        // reset after 10 accepted pairs discards them
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("part_ready%0d", k), bus.in_ready, 1);
            bus.in_valid = 1'b1; bus.in_a = 8'h44; bus.in_b = 8'h00;
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        clear_vec();
        for (int k = 0; k < N2; k++) add(8'h10, 8'h03, 8'h0D, 1'b0);
        run(N2);
        verify("rst");

        // two matrices back to back
        clear_vec();
        for (int k = 0; k < N2; k++) add(8'h33, 8'h11, 8'h22, 1'b0);
        for (int k = 0; k < N2; k++) add(8'h01, 8'h02, NEG_ONE, 1'b1);
        run(2 * N2);
        verify("b2b");
        if (acc_cyc.size() > N2 && hs_cyc.size() >= N2)
            chk("b2b_restart", acc_cyc[N2] - hs_cyc[N2-1], 1);
        else
            chk("b2b_restart_missing", 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
